// File: rtl/cpu_ctrl_pkg.sv
// Shared opcodes, ALU selects, instruction classes, FSM states and the
// packed control-line bundle for the hardwired control sequencer.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_ADD = 5'd0;
    localparam logic [4:0] ALU_AND = 5'd1;
    localparam logic [4:0] ALU_OR  = 5'd2;

    typedef enum logic [3:0] {
        CLS_LD, CLS_LDI, CLS_ST, CLS_ADD, CLS_AND, CLS_OR, CLS_BR, CLS_NOP, CLS_HALT
    } instr_class_e;

    typedef enum logic [4:0] {
        S_RESET, S_FETCH0, S_FETCH1, S_FETCH2,
        S_ADD_T3, S_ADD_T4, S_AND_T3, S_AND_T4, S_OR_T3, S_OR_T4, S_ALU_T5,
        S_LDI_T3, S_LDI_T4, S_LDI_T5,
        S_LD_T3, S_LD_T4, S_LD_T5, S_LD_T6, S_LD_T7,
        S_ST_T3, S_ST_T4, S_ST_T5, S_ST_T6, S_ST_T7,
        S_BR_T3, S_BR_T4, S_BR_T5, S_BR_T6,
        S_HALT
    } state_e;

    // Field order matches the concatenation onto the interface in the top.
    typedef struct packed {
        logic pc_out;
        logic zhigh_out;
        logic zlow_out;
        logic mdr_out;
        logic ba_out;
        logic c_out;
        logic r_out;
        logic mar_in;
        logic pc_in;
        logic mdr_in;
        logic ir_in;
        logic y_in;
        logic zhigh_in;
        logic zlow_in;
        logic r_in;
        logic con_in;
        logic inc_pc;
        logic gra;
        logic grb;
        logic grc;
        logic read;
        logic write;
        logic instr_done;
        logic illegal;
        logic halted;
    } ctrl_t;

endpackage

// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer (master) and the datapath (slave).
interface control_sequencer_if #(
    parameter int OPW = 5
);
    logic           run;
    logic [31:0]    ir;
    logic           branchCompare;
    logic           PCout, Zhighout, Zlowout, MDRout, BAOut, Cout, Rout;
    logic           MARin, PCin, MDRin, IRin, Yin, ZHighin, Zlowin, Rin, CONin, IncPC;
    logic           Gra, Grb, Grc;
    logic           Read, Write;
    logic [OPW-1:0] op;
    logic           instr_done, illegal, halted;

    modport master (
        input  run, ir, branchCompare,
        output PCout, Zhighout, Zlowout, MDRout, BAOut, Cout, Rout,
        output MARin, PCin, MDRin, IRin, Yin, ZHighin, Zlowin, Rin, CONin, IncPC,
        output Gra, Grb, Grc, Read, Write, op, instr_done, illegal, halted
    );

    modport slave (
        output run, ir, branchCompare,
        input  PCout, Zhighout, Zlowout, MDRout, BAOut, Cout, Rout,
        input  MARin, PCin, MDRin, IRin, Yin, ZHighin, Zlowin, Rin, CONin, IncPC,
        input  Gra, Grb, Grc, Read, Write, op, instr_done, illegal, halted
    );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode decode: maps the IR opcode field to an instruction
// class; unknown opcodes behave as NOP and raise the illegal flag.
module ctrl_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int DECODE_FIELD_MSB = 31
) (
    input  logic [31:0]  ir,
    output instr_class_e cls,
    output logic         illegal
);

    logic [4:0] opcode;
    logic       unused_ir;

    assign opcode    = ir[DECODE_FIELD_MSB -: 5];
    assign unused_ir = ^ir;

    always_comb begin
        cls     = CLS_NOP;
        illegal = 1'b0;
        case (opcode)
            OP_LD:   cls = CLS_LD;
            OP_LDI:  cls = CLS_LDI;
            OP_ST:   cls = CLS_ST;
            OP_ADDI: cls = CLS_ADD;
            OP_ANDI: cls = CLS_AND;
            OP_ORI:  cls = CLS_OR;
            OP_BR:   cls = CLS_BR;
            OP_NOP:  cls = CLS_NOP;
            OP_HALT: cls = CLS_HALT;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch, decode and per-instruction T-state sequencing
// that drives the datapath control lines one cycle at a time.
//
// state        | meaning
// RESET        | held by clear, all outputs 0
// FETCH0       | PC -> MAR, PC+1 -> Z; stalls while run=0
// FETCH1       | Z -> PC, memory read into MDR
// FETCH2       | MDR -> IR, decode; NOP/unknown finish here
// <op>_T3..T7  | per-instruction execute steps
// HALT         | halted=1 until clear
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW              = 5,
    parameter int DECODE_FIELD_MSB = 31
) (
    input logic                 Clock,
    input logic                 clear,
    control_sequencer_if.master bus
);

    state_e         state_q, state_d;
    ctrl_t          ctrl_c;
    logic [OPW-1:0] op_c;
    instr_class_e   dec_cls;
    logic           dec_illegal;

    ctrl_decode #(.DECODE_FIELD_MSB(DECODE_FIELD_MSB)) u_decode (
        .ir      (bus.ir),
        .cls     (dec_cls),
        .illegal (dec_illegal)
    );

    always_ff @(posedge Clock) begin
        if (clear) state_q <= S_RESET;
        else       state_q <= state_d;
    end

    always_comb begin
        ctrl_c  = '0;
        op_c    = OPW'(ALU_ADD);
        state_d = S_RESET;

        case (state_q)
            S_FETCH0: if (bus.run) begin
                ctrl_c.pc_out   = 1'b1;
                ctrl_c.mar_in   = 1'b1;
                ctrl_c.inc_pc   = 1'b1;
                ctrl_c.zhigh_in = 1'b1;
                ctrl_c.zlow_in  = 1'b1;
            end
            S_FETCH1: begin
                ctrl_c.zlow_out = 1'b1;
                ctrl_c.pc_in    = 1'b1;
                ctrl_c.read     = 1'b1;
                ctrl_c.mdr_in   = 1'b1;
            end
            S_FETCH2: begin
                ctrl_c.mdr_out    = 1'b1;
                ctrl_c.ir_in      = 1'b1;
                ctrl_c.instr_done = (dec_cls == CLS_NOP);
                ctrl_c.illegal    = dec_illegal;
            end
            S_ADD_T3, S_AND_T3, S_OR_T3: begin
                ctrl_c.grb   = 1'b1;
                ctrl_c.r_out = 1'b1;
                ctrl_c.y_in  = 1'b1;
            end
            S_LDI_T3, S_LD_T3, S_ST_T3: begin
                ctrl_c.grb    = 1'b1;
                ctrl_c.ba_out = 1'b1;
                ctrl_c.y_in   = 1'b1;
            end
            S_ADD_T4, S_AND_T4, S_OR_T4, S_LDI_T4, S_LD_T4, S_ST_T4, S_BR_T5: begin
                ctrl_c.c_out    = 1'b1;
                ctrl_c.zhigh_in = 1'b1;
                ctrl_c.zlow_in  = 1'b1;
                if (state_q == S_AND_T4) op_c = OPW'(ALU_AND);
                if (state_q == S_OR_T4)  op_c = OPW'(ALU_OR);
            end
            S_ALU_T5, S_LDI_T5: begin
                ctrl_c.zlow_out   = 1'b1;
                ctrl_c.gra        = 1'b1;
                ctrl_c.r_in       = 1'b1;
                ctrl_c.instr_done = 1'b1;
            end
            S_LD_T5, S_ST_T5: begin
                ctrl_c.zlow_out = 1'b1;
                ctrl_c.mar_in   = 1'b1;
            end
            S_LD_T6: begin
                ctrl_c.read   = 1'b1;
                ctrl_c.mdr_in = 1'b1;
            end
            S_LD_T7: begin
                ctrl_c.mdr_out    = 1'b1;
                ctrl_c.gra        = 1'b1;
                ctrl_c.r_in       = 1'b1;
                ctrl_c.instr_done = 1'b1;
            end
            S_ST_T6: begin
                ctrl_c.gra    = 1'b1;
                ctrl_c.r_out  = 1'b1;
                ctrl_c.mdr_in = 1'b1;
            end
            S_ST_T7: begin
                ctrl_c.write      = 1'b1;
                ctrl_c.instr_done = 1'b1;
            end
            S_BR_T3: begin
                ctrl_c.gra    = 1'b1;
                ctrl_c.r_out  = 1'b1;
                ctrl_c.con_in = 1'b1;
            end
            S_BR_T4: begin
                ctrl_c.pc_out = 1'b1;
                ctrl_c.y_in   = 1'b1;
            end
            S_BR_T6: begin
                ctrl_c.zlow_out   = bus.branchCompare;
                ctrl_c.pc_in      = bus.branchCompare;
                ctrl_c.instr_done = 1'b1;
            end
            S_HALT: ctrl_c.halted = 1'b1;
            default: ;
        endcase

        case (state_q)
            S_RESET:  state_d = S_FETCH0;
            S_FETCH0: state_d = bus.run ? S_FETCH1 : S_FETCH0;
            S_FETCH1: state_d = S_FETCH2;
            S_FETCH2: begin
                case (dec_cls)
                    CLS_ADD:  state_d = S_ADD_T3;
                    CLS_AND:  state_d = S_AND_T3;
                    CLS_OR:   state_d = S_OR_T3;
                    CLS_LDI:  state_d = S_LDI_T3;
                    CLS_LD:   state_d = S_LD_T3;
                    CLS_ST:   state_d = S_ST_T3;
                    CLS_BR:   state_d = S_BR_T3;
                    CLS_HALT: state_d = S_HALT;
                    default:  state_d = S_FETCH0;
                endcase
            end
            S_ADD_T3: state_d = S_ADD_T4;
            S_AND_T3: state_d = S_AND_T4;
            S_OR_T3:  state_d = S_OR_T4;
            S_ADD_T4, S_AND_T4, S_OR_T4: state_d = S_ALU_T5;
            S_LDI_T3: state_d = S_LDI_T4;
            S_LDI_T4: state_d = S_LDI_T5;
            S_LD_T3:  state_d = S_LD_T4;
            S_LD_T4:  state_d = S_LD_T5;
            S_LD_T5:  state_d = S_LD_T6;
            S_LD_T6:  state_d = S_LD_T7;
            S_ST_T3:  state_d = S_ST_T4;
            S_ST_T4:  state_d = S_ST_T5;
            S_ST_T5:  state_d = S_ST_T6;
            S_ST_T6:  state_d = S_ST_T7;
            S_BR_T3:  state_d = S_BR_T4;
            S_BR_T4:  state_d = S_BR_T5;
            S_BR_T5:  state_d = S_BR_T6;
            S_ALU_T5, S_LDI_T5, S_LD_T7, S_ST_T7, S_BR_T6: state_d = S_FETCH0;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_RESET;
        endcase
    end

    assign {bus.PCout, bus.Zhighout, bus.Zlowout, bus.MDRout, bus.BAOut, bus.Cout, bus.Rout,
            bus.MARin, bus.PCin, bus.MDRin, bus.IRin, bus.Yin, bus.ZHighin, bus.Zlowin,
            bus.Rin, bus.CONin, bus.IncPC, bus.Gra, bus.Grb, bus.Grc, bus.Read, bus.Write,
            bus.instr_done, bus.illegal, bus.halted} = ctrl_c;
    assign bus.op = op_c;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed cycle-by-cycle check of every control line against hand-built
// per-instruction T-state tables.
module tb_control_sequencer;
    import cpu_ctrl_pkg::*;

    logic Clock = 1'b0;
    logic clear;
    always #5 Clock = ~Clock;

    control_sequencer_if #(.OPW(5)) bus ();

    control_sequencer #(.OPW(5), .DECODE_FIELD_MSB(31)) dut (
        .Clock (Clock),
        .clear (clear),
        .bus   (bus)
    );

    localparam logic [24:0] M_PCOUT  = 25'd1 << 24;
    localparam logic [24:0] M_ZHOUT  = 25'd1 << 23;
    localparam logic [24:0] M_ZLOUT  = 25'd1 << 22;
    localparam logic [24:0] M_MDROUT = 25'd1 << 21;
    localparam logic [24:0] M_BAOUT  = 25'd1 << 20;
    localparam logic [24:0] M_COUT   = 25'd1 << 19;
    localparam logic [24:0] M_ROUT   = 25'd1 << 18;
    localparam logic [24:0] M_MARIN  = 25'd1 << 17;
    localparam logic [24:0] M_PCIN   = 25'd1 << 16;
    localparam logic [24:0] M_MDRIN  = 25'd1 << 15;
    localparam logic [24:0] M_IRIN   = 25'd1 << 14;
    localparam logic [24:0] M_YIN    = 25'd1 << 13;
    localparam logic [24:0] M_ZHIN   = 25'd1 << 12;
    localparam logic [24:0] M_ZLIN   = 25'd1 << 11;
    localparam logic [24:0] M_RIN    = 25'd1 << 10;
    localparam logic [24:0] M_CONIN  = 25'd1 << 9;
    localparam logic [24:0] M_INCPC  = 25'd1 << 8;
    localparam logic [24:0] M_GRA    = 25'd1 << 7;
    localparam logic [24:0] M_GRB    = 25'd1 << 6;
    localparam logic [24:0] M_READ   = 25'd1 << 4;
    localparam logic [24:0] M_WRITE  = 25'd1 << 3;
    localparam logic [24:0] M_DONE   = 25'd1 << 2;
    localparam logic [24:0] M_ILL    = 25'd1 << 1;
    localparam logic [24:0] M_HALTED = 25'd1 << 0;

    localparam logic [29:0] E_ZERO = 30'd0;
    localparam logic [29:0] E_F0   = {ALU_ADD, M_PCOUT | M_MARIN | M_INCPC | M_ZHIN | M_ZLIN};
    localparam logic [29:0] E_F1   = {ALU_ADD, M_ZLOUT | M_PCIN | M_READ | M_MDRIN};
    localparam logic [29:0] E_F2   = {ALU_ADD, M_MDROUT | M_IRIN};
    localparam logic [29:0] E_F2N  = {ALU_ADD, M_MDROUT | M_IRIN | M_DONE};
    localparam logic [29:0] E_F2I  = {ALU_ADD, M_MDROUT | M_IRIN | M_DONE | M_ILL};
    localparam logic [29:0] E_A3   = {ALU_ADD, M_GRB | M_ROUT | M_YIN};
    localparam logic [29:0] E_ADD4 = {ALU_ADD, M_COUT | M_ZHIN | M_ZLIN};
    localparam logic [29:0] E_AND4 = {ALU_AND, M_COUT | M_ZHIN | M_ZLIN};
    localparam logic [29:0] E_OR4  = {ALU_OR,  M_COUT | M_ZHIN | M_ZLIN};
    localparam logic [29:0] E_WB   = {ALU_ADD, M_ZLOUT | M_GRA | M_RIN | M_DONE};
    localparam logic [29:0] E_M3   = {ALU_ADD, M_GRB | M_BAOUT | M_YIN};
    localparam logic [29:0] E_M5   = {ALU_ADD, M_ZLOUT | M_MARIN};
    localparam logic [29:0] E_LD6  = {ALU_ADD, M_READ | M_MDRIN};
    localparam logic [29:0] E_LD7  = {ALU_ADD, M_MDROUT | M_GRA | M_RIN | M_DONE};
    localparam logic [29:0] E_ST6  = {ALU_ADD, M_GRA | M_ROUT | M_MDRIN};
    localparam logic [29:0] E_ST7  = {ALU_ADD, M_WRITE | M_DONE};
    localparam logic [29:0] E_BR3  = {ALU_ADD, M_GRA | M_ROUT | M_CONIN};
    localparam logic [29:0] E_BR4  = {ALU_ADD, M_PCOUT | M_YIN};
    localparam logic [29:0] E_BR6T = {ALU_ADD, M_ZLOUT | M_PCIN | M_DONE};
    localparam logic [29:0] E_BR6N = {ALU_ADD, M_DONE};
    localparam logic [29:0] E_HALT = {ALU_ADD, M_HALTED};

    logic [29:0] obs;
    assign obs = {bus.op, bus.PCout, bus.Zhighout, bus.Zlowout, bus.MDRout, bus.BAOut,
                  bus.Cout, bus.Rout, bus.MARin, bus.PCin, bus.MDRin, bus.IRin, bus.Yin,
                  bus.ZHighin, bus.Zlowin, bus.Rin, bus.CONin, bus.IncPC, bus.Gra, bus.Grb,
                  bus.Grc, bus.Read, bus.Write, bus.instr_done, bus.illegal, bus.halted};

    int          n_chk = 0;
    int          n_bad = 0;
    logic [29:0] seq[$];

    task automatic chk_eq(input string tag, input logic [29:0] got, input logic [29:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs change just after a rising edge; outputs are sampled on the falling edge.
    task automatic expect_cyc(input string tag, input logic [29:0] exp);
        @(negedge Clock);
        chk_eq(tag, obs, exp);
        @(posedge Clock);
        #1;
    endtask

    task automatic run_seq(input string tag, input logic [31:0] word);
        bus.ir = word;
        for (int i = 0; i < seq.size(); i++)
            expect_cyc($sformatf("%s_t%0d", tag, i), seq[i]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        clear             = 1'b1;
        bus.run           = 1'b0;
        bus.ir            = 32'd0;
        bus.branchCompare = 1'b0;
        repeat (2) @(posedge Clock);
        #1;

        expect_cyc("reset", E_ZERO);
        clear = 1'b0;
        expect_cyc("reset_exit", E_ZERO);
        for (int i = 0; i < 5; i++) expect_cyc($sformatf("stall_%0d", i), E_ZERO);
        bus.run = 1'b1;

        seq = {E_F0, E_F1, E_F2, E_A3, E_ADD4, E_WB};
        run_seq("addi", {OP_ADDI, 4'd3, 4'd4, 19'd53});
        seq = {E_F0, E_F1, E_F2, E_A3, E_AND4, E_WB};
        run_seq("andi", {OP_ANDI, 27'd7});
        seq = {E_F0, E_F1, E_F2, E_A3, E_OR4, E_WB};
        run_seq("ori", {OP_ORI, 27'd9});
        seq = {E_F0, E_F1, E_F2, E_M3, E_ADD4, E_WB};
        run_seq("ldi", {OP_LDI, 27'd5});
        seq = {E_F0, E_F1, E_F2, E_M3, E_ADD4, E_M5, E_ST6, E_ST7};
        run_seq("st", {OP_ST, 4'd1, 4'd0, 19'h40});
        seq = {E_F0, E_F1, E_F2, E_M3, E_ADD4, E_M5, E_LD6, E_LD7};
        run_seq("ld", {OP_LD, 4'd2, 4'd0, 19'h40});

        bus.branchCompare = 1'b1;
        seq = {E_F0, E_F1, E_F2, E_BR3, E_BR4, E_ADD4, E_BR6T};
        run_seq("br_taken", {OP_BR, 4'd1, 4'd0, 19'd8});
        bus.branchCompare = 1'b0;
        seq = {E_F0, E_F1, E_F2, E_BR3, E_BR4, E_ADD4, E_BR6N};
        run_seq("br_not", {OP_BR, 4'd1, 4'd0, 19'd8});

        seq = {E_F0, E_F1, E_F2N};
        run_seq("nop", {OP_NOP, 27'd0});
        seq = {E_F0, E_F1, E_F2I, E_F0};
        run_seq("illegal", {5'b11111, 27'd0});

        // clear lands during LD T6: T7 never appears, RESET then FETCH0
        seq = {E_F1, E_F2, E_M3, E_ADD4, E_M5};
        run_seq("ld_clr", {OP_LD, 4'd2, 4'd0, 19'h40});
        clear = 1'b1;
        expect_cyc("ld_clr_t6", E_LD6);
        clear = 1'b0;
        expect_cyc("ld_clr_rst", E_ZERO);
        seq = {E_F0, E_F1, E_F2, E_M3, E_ADD4, E_M5, E_LD6, E_LD7};
        run_seq("ld_after", {OP_LD, 4'd2, 4'd0, 19'h40});

        seq = {E_F0, E_F1, E_F2, E_HALT, E_HALT, E_HALT};
        run_seq("halt", {OP_HALT, 27'd0});
        bus.ir  = {5'b11111, 27'd0};
        bus.run = 1'b0;
        expect_cyc("halt_hold0", E_HALT);
        expect_cyc("halt_hold1", E_HALT);
        bus.run = 1'b1;
        clear   = 1'b1;
        expect_cyc("halt_clr", E_HALT);
        clear = 1'b0;
        expect_cyc("halt_rst", E_ZERO);
        expect_cyc("halt_f0", E_F0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
